nf10_output_dispatcher: RTL and testbench

Round-trip counterpart of the input arbiter: one AXI4-Stream slave carrying packets from the data path is fanned out to NUM_QUEUES per-port AXI4-Stream masters (toward the TX MACs / DMA).
- Destination comes from a one-hot/multi-hot port bitmap in tuser.
- Each output owns a fall-through FIFO.
- Admission is per packet, so a packet is always written completely into every selected queue.
- Packets with an empty bitmap are dropped and counted.

---
 rtl/nf10_output_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_nf10_output_dispatcher.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_output_dispatcher.sv
`default_nettype none
// ============================================================================
// Module  : nf10_output_dispatcher
// Purpose : Fans one AXI4-Stream out to NUM_QUEUES fall-through FIFOs,
//           steered by a per-packet port bitmap carried in tuser.
// Revision: 1.0 - initial release
// ============================================================================
module nf10_output_dispatcher #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 5,
    parameter int DST_PORT_POS         = 24,
    parameter int QUEUE_DEPTH_BITS     = 7,
    parameter int MAX_PKT_WORDS        = 63
) (
    input  logic                                           axi_aclk,
    input  logic                                           axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]               s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]                s_axis_tuser,
    input  logic                                           s_axis_tvalid,
    output logic                                           s_axis_tready,
    input  logic                                           s_axis_tlast,
    output logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [NUM_QUEUES*C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [NUM_QUEUES*C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                          m_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                          m_axis_tready,
    output logic [NUM_QUEUES-1:0]                          m_axis_tlast,
    output logic [31:0]                                    pkt_drop_count
);
    localparam int DEPTH    = 1 << QUEUE_DEPTH_BITS;
    localparam int S_STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int M_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W  = 1 + C_S_AXIS_TUSER_WIDTH + S_STRB_W + C_S_AXIS_DATA_WIDTH;
    localparam logic [QUEUE_DEPTH_BITS:0] FULL_CNT = {1'b1, {QUEUE_DEPTH_BITS{1'b0}}};
    localparam logic [QUEUE_DEPTH_BITS:0] PKT_ROOM = (QUEUE_DEPTH_BITS+1)'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PKT = 2'd1,
        DROP   = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_QUEUES-1:0]             dst_q, dst_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_q, tuser_d;
    logic [31:0]                       drop_cnt_q;

    logic [NUM_QUEUES-1:0]             w_dst_in;
    logic [NUM_QUEUES-1:0]             w_full;
    logic [NUM_QUEUES-1:0]             w_room;
    logic [NUM_QUEUES-1:0]             w_wr_ok;
    logic [NUM_QUEUES-1:0]             w_push;
    logic                              w_ready;
    logic                              w_drop_last;
    logic [ENTRY_W-1:0]                w_wr_entry;

    assign w_dst_in       = s_axis_tuser[DST_PORT_POS +: NUM_QUEUES];
    assign s_axis_tready  = w_ready & ~axi_reset;
    assign pkt_drop_count = drop_cnt_q;
    // Mid-packet words carry the tuser captured with the first word.
    assign w_wr_entry = {s_axis_tlast,
                         (state_q == WR_PKT) ? tuser_q : s_axis_tuser,
                         s_axis_tstrb, s_axis_tdata};

    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        tuser_d     = tuser_q;
        w_ready     = 1'b0;
        w_push      = '0;
        w_drop_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_dst_in == '0) begin
                    w_ready = 1'b1;
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast) w_drop_last = 1'b1;
                        else              state_d     = DROP;
                    end
                end else begin
                    w_ready = &(w_room | ~w_dst_in);
                    if (s_axis_tvalid && w_ready) begin
                        dst_d   = w_dst_in;
                        tuser_d = s_axis_tuser;
                        w_push  = w_dst_in;
                        if (!s_axis_tlast) state_d = WR_PKT;
                    end
                end
            end
            WR_PKT: begin
                w_ready = &(w_wr_ok | ~dst_q);
                if (s_axis_tvalid && w_ready) begin
                    w_push = dst_q;
                    if (s_axis_tlast) state_d = IDLE;
                end
            end
            DROP: begin
                w_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_drop_last = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= IDLE;
            dst_q      <= '0;
            tuser_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            tuser_q <= tuser_d;
            if (w_drop_last && (drop_cnt_q != 32'hFFFF_FFFF))
                drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
        logic [ENTRY_W-1:0]          mem_q [DEPTH];
        logic [QUEUE_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
        logic [QUEUE_DEPTH_BITS:0]   count_q;
        logic [ENTRY_W-1:0]          w_rd_entry;
        logic                        w_pop;

        assign w_full[i]        = (count_q == FULL_CNT);
        assign w_room[i]        = ((FULL_CNT - count_q) >= PKT_ROOM);
        // A full queue that pops this cycle can still take a word.
        assign w_wr_ok[i]       = ~w_full[i] | m_axis_tready[i];
        assign m_axis_tvalid[i] = (count_q != '0);
        assign w_pop            = m_axis_tvalid[i] & m_axis_tready[i];
        assign w_rd_entry       = mem_q[rd_ptr_q];

        assign m_axis_tdata[i*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH] =
            w_rd_entry[0 +: C_M_AXIS_DATA_WIDTH];
        assign m_axis_tstrb[i*M_STRB_W +: M_STRB_W] =
            w_rd_entry[C_S_AXIS_DATA_WIDTH +: M_STRB_W];
        assign m_axis_tuser[i*C_M_AXIS_TUSER_WIDTH +: C_M_AXIS_TUSER_WIDTH] =
            w_rd_entry[C_S_AXIS_DATA_WIDTH+S_STRB_W +: C_M_AXIS_TUSER_WIDTH];
        assign m_axis_tlast[i] = w_rd_entry[ENTRY_W-1];

        always_ff @(posedge axi_aclk) begin
            if (w_push[i]) mem_q[wr_ptr_q] <= w_wr_entry;
        end

        always_ff @(posedge axi_aclk or posedge axi_reset) begin
            if (axi_reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_push[i]) wr_ptr_q <= wr_ptr_q + QUEUE_DEPTH_BITS'(1);
                if (w_pop)     rd_ptr_q <= rd_ptr_q + QUEUE_DEPTH_BITS'(1);
                if (w_push[i] && !w_pop)
                    count_q <= count_q + (QUEUE_DEPTH_BITS+1)'(1);
                else if (w_pop && !w_push[i])
                    count_q <= count_q - (QUEUE_DEPTH_BITS+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nf10_output_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_nf10_output_dispatcher
// Purpose : Self-checking bench with a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nf10_output_dispatcher;
    localparam int DW = 256, UW = 128, NQ = 5, SW = DW/8, POS = 24;
    localparam int DEPTH = 128, MAXW = 63;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_tdata;
    logic [SW-1:0]     s_tstrb;
    logic [UW-1:0]     s_tuser;
    logic              s_tvalid, s_tready, s_tlast;
    logic [NQ*DW-1:0]  m_tdata;
    logic [NQ*SW-1:0]  m_tstrb;
    logic [NQ*UW-1:0]  m_tuser;
    logic [NQ-1:0]     m_tvalid, m_tready, m_tlast;
    logic [31:0]       drop_cnt;

    always #5 clk = ~clk;

    nf10_output_dispatcher dut (
        .axi_aclk(clk), .axi_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .pkt_drop_count(drop_cnt)
    );

    typedef struct packed {
        logic          l;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        logic [DW-1:0] d;
    } word_t;

    typedef struct {
        logic [7:0]    bm;
        int            len;
        logic [NQ-1:0] exp_mask;
        int            exp_drop;
    } vec_t;

    word_t         mq[NQ][$];
    bit            chk_en = 1'b0;
    bit            rnd_rdy = 1'b0;
    bit            mdl_busy, mdl_drop, mdl_acc;
    logic [NQ-1:0] mdl_dst;
    logic [UW-1:0] mdl_user;
    int            mdl_drops;
    int            rx_cnt[NQ];
    int            dut_acc;
    int            checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input int q, input word_t a, input word_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL q%0d_word: got %h expected %h", q, a, e);
        end
    endtask

    function automatic word_t get_word(input int i);
        word_t r;
        r.d = m_tdata[i*DW +: DW];
        r.s = m_tstrb[i*SW +: SW];
        r.u = m_tuser[i*UW +: UW];
        r.l = m_tlast[i];
        return r;
    endfunction

    function automatic bit mdl_empty();
        for (int i = 0; i < NQ; i++) if (mq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NQ; i++) mq[i].delete();
        mdl_busy = 0; mdl_drop = 0; mdl_drops = 0; mdl_acc = 0; mdl_dst = '0;
    endtask

    // Reference model: compares outputs, predicts ready, then applies the
    // transfers that the coming rising edge will perform.
    always @(negedge clk) begin : model
        logic [NQ-1:0] dstin;
        bit            rdy;
        word_t         w;
        for (int i = 0; i < NQ; i++)
            if (m_tvalid[i] === 1'b1 && m_tready[i]) rx_cnt[i]++;
        if (s_tvalid && s_tready === 1'b1) dut_acc++;
        if (chk_en) begin
            for (int i = 0; i < NQ; i++) begin
                chk("m_tvalid", 64'(m_tvalid[i]), 64'(mq[i].size() != 0));
                if (mq[i].size() != 0) chkw(i, get_word(i), mq[i][0]);
            end
            chk("drop_count", 64'(drop_cnt), 64'(mdl_drops));
            dstin = s_tuser[POS +: NQ];
            rdy   = 1'b1;
            if (mdl_busy) begin
                for (int i = 0; i < NQ; i++)
                    if (mdl_dst[i] && mq[i].size() >= DEPTH && !m_tready[i]) rdy = 1'b0;
            end else if (!mdl_drop && dstin != '0) begin
                for (int i = 0; i < NQ; i++)
                    if (dstin[i] && (DEPTH - mq[i].size()) < MAXW) rdy = 1'b0;
            end
            chk("s_tready", 64'(s_tready), 64'(rdy));
            mdl_acc = s_tvalid && rdy;
            for (int i = 0; i < NQ; i++)
                if (mq[i].size() != 0 && m_tready[i]) void'(mq[i].pop_front());
            if (mdl_acc) begin
                w.d = s_tdata; w.s = s_tstrb; w.l = s_tlast;
                if (mdl_busy) begin
                    w.u = mdl_user;
                    for (int i = 0; i < NQ; i++) if (mdl_dst[i]) mq[i].push_back(w);
                    if (s_tlast) mdl_busy = 0;
                end else if (mdl_drop) begin
                    if (s_tlast) begin mdl_drop = 0; mdl_drops++; end
                end else if (dstin == '0) begin
                    if (s_tlast) mdl_drops++;
                    else         mdl_drop = 1;
                end else begin
                    mdl_user = s_tuser; mdl_dst = dstin; w.u = s_tuser;
                    for (int i = 0; i < NQ; i++) if (dstin[i]) mq[i].push_back(w);
                    mdl_busy = !s_tlast;
                end
            end
        end else begin
            mdl_acc = 0;
        end
    end

    always @(posedge clk) if (rnd_rdy) begin
        #1;
        m_tready = NQ'($urandom | $urandom);
    end

    task automatic drive_word(input logic [7:0] bm, input bit last);
        for (int k = 0; k < DW/32; k++) s_tdata[k*32 +: 32] = $urandom;
        for (int k = 0; k < UW/32; k++) s_tuser[k*32 +: 32] = $urandom;
        s_tstrb           = $urandom;
        s_tuser[POS +: 8] = bm;
        s_tlast           = last;
        s_tvalid          = 1'b1;
    endtask

    // Call just after a rising edge; returns just after one.
    task automatic send_pkt(input logic [7:0] bm, input int len);
        for (int w = 0; w < len; w++) begin
            int guard = 0;
            drive_word((w == 0) ? bm : 8'($urandom), w == len - 1);
            do begin @(posedge clk); guard++; end while (!mdl_acc && guard < 3000);
            if (!mdl_acc) chk("send_timeout", 64'(guard), 64'(0));
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (!mdl_empty() && g < 5000) begin @(posedge clk); g++; end
        if (!mdl_empty()) chk("drain_timeout", 64'(g), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{8'h04, 4,    5'b00100, 0};
        tbl[1] = '{8'h00, 2,    5'b00000, 1};
        tbl[2] = '{8'h01, 1,    5'b00001, 1};
        tbl[3] = '{8'hE2, 3,    5'b00010, 1};
        tbl[4] = '{8'h1F, 2,    5'b11111, 1};
        tbl[5] = '{8'h00, 1,    5'b00000, 2};
        tbl[6] = '{8'h13, MAXW, 5'b10011, 2};

        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0;
        s_tuser = '0; m_tready = '1;
        mdl_reset();
        #12;
        chk("rst_tready", 64'(s_tready), 64'(0));
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_drop",   64'(drop_cnt), 64'(0));
        #10 rst = 1'b0;
        #1 chk_en = 1'b1;
        @(posedge clk); #1;

        // Directed packet table: unicast, drops, ignored high bits, multicast.
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < NQ; i++) rx_cnt[i] = 0;
            send_pkt(tbl[r].bm, tbl[r].len);
            chk("tbl_drop", 64'(drop_cnt), 64'(tbl[r].exp_drop));
            drain();
            for (int i = 0; i < NQ; i++)
                chk("tbl_rx", 64'(rx_cnt[i]), 64'(tbl[r].exp_mask[i] ? tbl[r].len : 0));
        end

        // Multicast blocked by queue 4 at 66 words until it pops one.
        m_tready = 5'b01111;
        send_pkt(8'h10, 63);
        send_pkt(8'h10, 3);
        fork
            send_pkt(8'h13, 3);
            begin
                repeat (5) begin @(negedge clk); chk("mc_stall", 64'(s_tready), 64'(0)); end
                @(posedge clk); #1 m_tready[4] = 1'b1;
                @(posedge clk); #1 m_tready[4] = 1'b0;
            end
        join
        m_tready = '1;
        drain();

        // Oversize packet into a stalled queue 3: fills to exactly 128.
        m_tready = 5'b10111;
        dut_acc = 0;
        send_pkt(8'h08, 63);
        fork
            send_pkt(8'h08, 70);
            begin
                int g = 0;
                while (mq[3].size() < DEPTH && g < 1000) begin @(negedge clk); g++; end
                repeat (3) @(negedge clk);
                chk("full_acc",   64'(dut_acc),  64'(128));
                chk("full_stall", 64'(s_tready), 64'(0));
                @(posedge clk); #1 m_tready[3] = 1'b1;
                @(posedge clk); #1 m_tready[3] = 1'b0;
                repeat (3) @(negedge clk);
                chk("one_more", 64'(dut_acc), 64'(129));
                @(posedge clk); #1 m_tready[3] = 1'b1;
                repeat (2) @(posedge clk);
                #1 m_tready[3] = 1'b0;
                @(negedge clk);
                chk("pushpop_acc",  64'(dut_acc),  64'(131));
                chk("pushpop_full", 64'(s_tready), 64'(0));
                @(posedge clk); #1 m_tready = '1;
            end
        join
        drain();

        // Randomized traffic with random backpressure.
        rnd_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            logic [7:0] bm;
            int         len;
            bm  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW, MAXW + 20)
                                              : $urandom_range(1, MAXW);
            send_pkt(bm, len);
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2 m_tready = '1;
        drain();

        // Asynchronous reset in the middle of a packet.
        chk_en = 1'b0;
        drive_word(8'h02, 1'b0);
        @(posedge clk); #1 drive_word(8'($urandom), 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 64'(m_tvalid[1]), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_tvalid", 64'(m_tvalid), 64'(0));
        chk("async_tready", 64'(s_tready), 64'(0));
        chk("async_drop",   64'(drop_cnt), 64'(0));
        s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        mdl_reset();
        #1 chk_en = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NQ; i++) rx_cnt[i] = 0;
        send_pkt(8'h02, 1);
        drain();
        for (int i = 0; i < NQ; i++)
            chk("post_rst_rx", 64'(rx_cnt[i]), 64'((i == 1) ? 1 : 0));
        chk("post_rst_drop", 64'(drop_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
